// File: rtl/memory_access_unit_if.sv
// memory_access_unit_if -- data-memory request/response bus.
//   dmem_req   : request valid, held until ack or timeout
//   dmem_we    : 1 = write, 0 = read
//   dmem_addr  : byte address aligned down to the bus width
//   dmem_wdata : lane-positioned write data
//   dmem_be    : byte enables
//   dmem_ack   : request completed (from memory)
//   dmem_rdata : read data, valid with dmem_ack
// master = memory_access_unit side, slave = memory side.
interface memory_access_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    dmem_req;
  logic                    dmem_we;
  logic [ADDR_WIDTH-1:0]   dmem_addr;
  logic [DATA_WIDTH-1:0]   dmem_wdata;
  logic [DATA_WIDTH/8-1:0] dmem_be;
  logic                    dmem_ack;
  logic [DATA_WIDTH-1:0]   dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/memory_access_unit.sv
// memory_access_unit -- MEM pipeline stage.
// Non-memory instructions pass to the WB-side outputs with one cycle of
// latency. Loads/stores issue one request on the dmem bus and wait (stalling
// upstream) for dmem_ack, up to ACK_TIMEOUT cycles; misaligned accesses and
// timeouts complete with an error pulse and reg_wr_en_out forced low.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   valid_in ... instruction_in : EX-stage instruction and sideband
//   stall_out           : upstream must hold inputs while high
//   dmem                : data-memory bus (master modport)
//   valid_out ... instruction_out : registered WB-side outputs
//   misalign_err_out, bus_err_out : one-cycle error pulses with valid_out
// mem_data_out is 0 for every completion that is not a load.
module memory_access_unit #(
  parameter int DATA_WIDTH        = 32,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int ADDR_WIDTH        = 32,
  parameter int ACK_TIMEOUT       = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  input  logic                         mem_rd_en_in,
  input  logic                         mem_wr_en_in,
  input  logic [1:0]                   mem_size_in,
  input  logic                         mem_signed_in,
  input  logic [DATA_WIDTH-1:0]        alu_data_in,
  input  logic [DATA_WIDTH-1:0]        store_data_in,
  input  logic                         write_back_mux_sel_in,
  input  logic                         reg_wr_en_in,
  input  logic [REG_ADDR_WIDTH-1:0]    reg_wr_addr_in,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction_in,
  output logic                         stall_out,
  memory_access_unit_if.master         dmem,
  output logic                         valid_out,
  output logic                         write_back_mux_sel_out,
  output logic [DATA_WIDTH-1:0]        alu_data_out,
  output logic [DATA_WIDTH-1:0]        mem_data_out,
  output logic                         reg_wr_en_out,
  output logic [REG_ADDR_WIDTH-1:0]    reg_wr_addr_out,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
  output logic                         misalign_err_out,
  output logic                         bus_err_out
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(NBYTES);
  localparam int CNT_W  = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    wait_cnt_q;
  logic                wr_en_q;
  logic                is_load_q;
  logic                signed_q;
  logic [1:0]          size_q;
  logic [LANE_W-1:0]   lane_q;

  logic                  is_mem_d;
  logic                  misalign_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [LANE_W-1:0]     lane_d;
  logic [NBYTES-1:0]     be_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [DATA_WIDTH-1:0] rshift_d;
  logic [DATA_WIDTH-1:0] ld_mask_d;
  logic [DATA_WIDTH-1:0] load_d;
  logic                  sign_d;

  // 1/2/4/8 low byte lanes set for size 0/1/2/3.
  function automatic logic [NBYTES-1:0] byte_mask(input logic [1:0] size);
    logic [NBYTES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NBYTES; i++)
      if (i < (32'd1 << size)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] bit_mask(input logic [NBYTES-1:0] bm);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NBYTES; i++)
      m[i*8 +: 8] = {8{bm[i]}};
    return m;
  endfunction

  // Request side, decoded from the live inputs.
  always_comb begin
    addr_d   = alu_data_in[ADDR_WIDTH-1:0];
    lane_d   = addr_d[LANE_W-1:0];
    is_mem_d = mem_rd_en_in | mem_wr_en_in;
    case (mem_size_in)
      2'd0:    misalign_d = 1'b0;
      2'd1:    misalign_d = addr_d[0];
      2'd2:    misalign_d = |addr_d[1:0];
      default: misalign_d = (DATA_WIDTH == 32) || (|addr_d[2:0]);
    endcase
    be_d    = byte_mask(mem_size_in) << lane_d;
    wdata_d = (store_data_in & bit_mask(byte_mask(mem_size_in))) << {lane_d, 3'b000};
  end

  // Response side, using the access attributes captured at issue.
  always_comb begin
    rshift_d  = dmem.dmem_rdata >> {lane_q, 3'b000};
    ld_mask_d = bit_mask(byte_mask(size_q));
    case (size_q)
      2'd0:    sign_d = rshift_d[7];
      2'd1:    sign_d = rshift_d[15];
      2'd2:    sign_d = rshift_d[31];
      default: sign_d = rshift_d[DATA_WIDTH-1];
    endcase
    load_d = (signed_q && sign_d) ? (rshift_d | ~ld_mask_d) : (rshift_d & ld_mask_d);
  end

  assign stall_out = rst_n && (state_q == BUSY) && !dmem.dmem_ack;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q                <= IDLE;
      wait_cnt_q             <= '0;
      wr_en_q                <= 1'b0;
      is_load_q              <= 1'b0;
      signed_q               <= 1'b0;
      size_q                 <= '0;
      lane_q                 <= '0;
      dmem.dmem_req          <= 1'b0;
      dmem.dmem_we           <= 1'b0;
      dmem.dmem_addr         <= '0;
      dmem.dmem_wdata        <= '0;
      dmem.dmem_be           <= '0;
      valid_out              <= 1'b0;
      write_back_mux_sel_out <= 1'b0;
      alu_data_out           <= '0;
      mem_data_out           <= '0;
      reg_wr_en_out          <= 1'b0;
      reg_wr_addr_out        <= '0;
      instruction_out        <= '0;
      misalign_err_out       <= 1'b0;
      bus_err_out            <= 1'b0;
    end else begin
      valid_out        <= 1'b0;
      reg_wr_en_out    <= 1'b0;
      misalign_err_out <= 1'b0;
      bus_err_out      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            // Sideband goes straight to the output registers; valid_out and
            // reg_wr_en_out stay low until the access completes.
            write_back_mux_sel_out <= write_back_mux_sel_in;
            alu_data_out           <= alu_data_in;
            reg_wr_addr_out        <= reg_wr_addr_in;
            instruction_out        <= instruction_in;
            mem_data_out           <= '0;
            if (!is_mem_d) begin
              valid_out     <= 1'b1;
              reg_wr_en_out <= reg_wr_en_in;
            end else if (misalign_d) begin
              valid_out        <= 1'b1;
              misalign_err_out <= 1'b1;
            end else begin
              state_q         <= BUSY;
              wait_cnt_q      <= '0;
              wr_en_q         <= reg_wr_en_in;
              is_load_q       <= !mem_wr_en_in;
              signed_q        <= mem_signed_in;
              size_q          <= mem_size_in;
              lane_q          <= lane_d;
              dmem.dmem_req   <= 1'b1;
              dmem.dmem_we    <= mem_wr_en_in;
              dmem.dmem_addr  <= {addr_d[ADDR_WIDTH-1:LANE_W], {LANE_W{1'b0}}};
              dmem.dmem_be    <= be_d;
              dmem.dmem_wdata <= wdata_d;
            end
          end
        end
        BUSY: begin
          if (dmem.dmem_ack) begin
            state_q       <= IDLE;
            dmem.dmem_req <= 1'b0;
            valid_out     <= 1'b1;
            reg_wr_en_out <= wr_en_q;
            mem_data_out  <= is_load_q ? load_d : '0;
          end else if (wait_cnt_q == LAST_WAIT) begin
            // The counter would reach ACK_TIMEOUT at this edge.
            state_q       <= IDLE;
            dmem.dmem_req <= 1'b0;
            valid_out     <= 1'b1;
            bus_err_out   <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
module tb_memory_access_unit;
  localparam int ACK_TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0, mem_rd_en_in = 1'b0, mem_wr_en_in = 1'b0;
  logic [1:0]  mem_size_in = '0;
  logic        mem_signed_in = 1'b0;
  logic [31:0] alu_data_in = '0, store_data_in = '0;
  logic        write_back_mux_sel_in = 1'b0, reg_wr_en_in = 1'b0;
  logic [4:0]  reg_wr_addr_in = '0;
  logic [31:0] instruction_in = '0;
  logic        stall_out, valid_out, write_back_mux_sel_out, reg_wr_en_out;
  logic [31:0] alu_data_out, mem_data_out, instruction_out;
  logic [4:0]  reg_wr_addr_out;
  logic        misalign_err_out, bus_err_out;

  memory_access_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  memory_access_unit #(
    .DATA_WIDTH(32), .INSTRUCTION_WIDTH(32), .REG_ADDR_WIDTH(5),
    .ADDR_WIDTH(32), .ACK_TIMEOUT(ACK_TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .mem_rd_en_in(mem_rd_en_in), .mem_wr_en_in(mem_wr_en_in),
    .mem_size_in(mem_size_in), .mem_signed_in(mem_signed_in),
    .alu_data_in(alu_data_in), .store_data_in(store_data_in),
    .write_back_mux_sel_in(write_back_mux_sel_in), .reg_wr_en_in(reg_wr_en_in),
    .reg_wr_addr_in(reg_wr_addr_in), .instruction_in(instruction_in),
    .stall_out(stall_out), .dmem(bus.master), .valid_out(valid_out),
    .write_back_mux_sel_out(write_back_mux_sel_out), .alu_data_out(alu_data_out),
    .mem_data_out(mem_data_out), .reg_wr_en_out(reg_wr_en_out),
    .reg_wr_addr_out(reg_wr_addr_out), .instruction_out(instruction_out),
    .misalign_err_out(misalign_err_out), .bus_err_out(bus_err_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid, wben, misal, buserr, wbsel, mem_chk;
    logic [31:0] alu, mem, instr;
    logic [4:0]  rd;
  } wb_t;

  typedef struct packed {
    logic        is_mem, misal, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
  } req_t;

  int   checks = 0, errors = 0;
  bit   chk_en = 0;
  wb_t  exp_wb;
  bit   exp_hold;
  bit   exp_req;
  req_t exp_rq;
  int   req_cycles = 0, stall_cycles = 0;
  logic [3:0]  seen_be;
  logic [31:0] seen_wdata;
  logic        seen_we;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, expv, $time);
    end
  endtask

  // Reference model: byte-addressed arithmetic on a 4-byte bus.
  function automatic req_t pred_req(input bit rd, input bit wr, input logic [1:0] size,
                                    input logic [31:0] alu, input logic [31:0] store);
    req_t r;
    longint unsigned a, n, lane, mask;
    a    = 64'(alu);
    n    = 64'd1 << size;
    lane = a % 4;
    mask = (64'd1 << (8 * n)) - 1;
    r.is_mem = rd | wr;
    r.we     = wr;
    r.misal  = (rd | wr) && (size == 2'd3 || (a % n) != 0);
    r.addr   = 32'(a - lane);
    r.be     = 4'(((64'd1 << n) - 1) << lane);
    r.wdata  = 32'((64'(store) & mask) << (8 * lane));
    return r;
  endfunction

  function automatic logic [31:0] pred_load(input logic [1:0] size, input bit sgn,
                                            input logic [31:0] alu, input logic [31:0] rdata);
    longint unsigned n, v;
    n = 64'd1 << size;
    v = (64'(rdata) >> (8 * (64'(alu) % 4))) % (64'd1 << (8 * n));
    if (sgn && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    return 32'(v);
  endfunction

  // One compare process, every cycle, at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("valid_out", 64'(valid_out), 64'(exp_wb.valid));
        chk("reg_wr_en_out", 64'(reg_wr_en_out), 64'(exp_wb.wben));
        chk("misalign_err_out", 64'(misalign_err_out), 64'(exp_wb.misal));
        chk("bus_err_out", 64'(bus_err_out), 64'(exp_wb.buserr));
        chk("dmem_req", 64'(bus.dmem_req), 64'(exp_req));
        chk("stall_out", 64'(stall_out), 64'(exp_req && rst_n && !bus.dmem_ack));
        if (exp_req) begin
          chk("dmem_we", 64'(bus.dmem_we), 64'(exp_rq.we));
          chk("dmem_addr", 64'(bus.dmem_addr), 64'(exp_rq.addr));
          chk("dmem_be", 64'(bus.dmem_be), 64'(exp_rq.be));
          chk("dmem_wdata", 64'(bus.dmem_wdata), 64'(exp_rq.wdata));
        end
        if (exp_wb.valid || exp_hold) begin
          chk("alu_data_out", 64'(alu_data_out), 64'(exp_wb.alu));
          chk("reg_wr_addr_out", 64'(reg_wr_addr_out), 64'(exp_wb.rd));
          chk("instruction_out", 64'(instruction_out), 64'(exp_wb.instr));
          chk("wb_mux_sel_out", 64'(write_back_mux_sel_out), 64'(exp_wb.wbsel));
          if (exp_wb.mem_chk) chk("mem_data_out", 64'(mem_data_out), 64'(exp_wb.mem));
        end
        if (bus.dmem_req === 1'b1) begin
          req_cycles++;
          seen_be = bus.dmem_be; seen_wdata = bus.dmem_wdata; seen_we = bus.dmem_we;
        end
        if (stall_out === 1'b1) stall_cycles++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_cycle();
    valid_in = 1'b0;
    alu_data_in = $urandom; instruction_in = $urandom; reg_wr_addr_in = 5'($urandom);
    reg_wr_en_in = 1'b1;
    @(posedge clk); #1;
    exp_wb.valid = 0; exp_wb.wben = 0; exp_wb.misal = 0; exp_wb.buserr = 0;
    exp_hold = 1;
  endtask

  // ack_cycle: BUSY cycle (1-based) in which ack is given; outside 1..ACK_TO means never.
  task automatic run_op(input bit rd, input bit wr, input logic [1:0] size, input bit sgn,
                        input logic [31:0] alu, input logic [31:0] store, input bit wbsel,
                        input bit wren, input logic [4:0] rdaddr, input logic [31:0] instr,
                        input int ack_cycle, input logic [31:0] rdata);
    req_t r;
    wb_t  w;
    bit   acked;
    r = pred_req(rd, wr, size, alu, store);
    valid_in = 1'b1; mem_rd_en_in = rd; mem_wr_en_in = wr; mem_size_in = size;
    mem_signed_in = sgn; alu_data_in = alu; store_data_in = store;
    write_back_mux_sel_in = wbsel; reg_wr_en_in = wren; reg_wr_addr_in = rdaddr;
    instruction_in = instr;
    w = '0;
    w.valid = 1; w.wben = wren; w.wbsel = wbsel; w.alu = alu; w.instr = instr; w.rd = rdaddr;
    @(posedge clk); #1;
    if (!r.is_mem) begin
      exp_wb = w;
    end else if (r.misal) begin
      w.wben = 0; w.misal = 1;
      exp_wb = w;
    end else begin
      exp_rq = r; exp_req = 1; exp_hold = 0;
      exp_wb.valid = 0; exp_wb.wben = 0; exp_wb.misal = 0; exp_wb.buserr = 0;
      acked = 0;
      for (int k = 1; k <= ACK_TO && !acked; k++) begin
        acked = (k == ack_cycle);
        bus.dmem_ack = acked;
        bus.dmem_rdata = acked ? rdata : $urandom;
        @(posedge clk); #1;
      end
      bus.dmem_ack = 1'b0;
      exp_req = 0;
      if (acked) begin
        w.mem_chk = 1;
        w.mem = wr ? 32'h0 : pred_load(size, sgn, alu, rdata);
      end else begin
        w.wben = 0; w.buserr = 1;
      end
      exp_wb = w;
    end
    valid_in = 1'b0;
    exp_hold = 1;
  endtask

  initial begin
    req_t pr;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = '0;
    exp_wb = '0; exp_wb.mem_chk = 1; exp_hold = 1; exp_req = 0; exp_rq = '0;

    // Reset: outputs all zero, stall low during and after reset.
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycle();
    exp_hold = 0;

    // Model pins against hand-computed values.
    chk("model_load_sb", 64'(pred_load(2'd0, 1'b1, 32'h1003, 32'h8000_0000)), 64'hFFFF_FF80);
    chk("model_load_uh", 64'(pred_load(2'd1, 1'b0, 32'h0002, 32'hABCD_1234)), 64'h0000_ABCD);
    pr = pred_req(1'b0, 1'b1, 2'd1, 32'h2002, 32'h1234_BEEF);
    chk("model_be_half", 64'(pr.be), 64'hC);
    chk("model_wdata_half", 64'(pr.wdata), 64'hBEEF_0000);
    chk("model_addr_half", 64'(pr.addr), 64'h2000);
    pr = pred_req(1'b1, 1'b0, 2'd2, 32'h0006, 32'h0);
    chk("model_misalign_word", 64'(pr.misal), 64'h1);

    // ALU op passes through.
    req_cycles = 0;
    run_op(0, 0, 2'd0, 0, 32'h1234, 32'h0, 0, 1, 5'd5, 32'h0000_0013, 0, 32'h0);
    chk("alu_valid", 64'(valid_out), 64'h1);
    chk("alu_data", 64'(alu_data_out), 64'h1234);
    chk("alu_rd", 64'(reg_wr_addr_out), 64'h5);
    chk("alu_no_req", 64'(req_cycles), 64'h0);
    idle_cycle();

    // Signed byte load at 0x1003, ack in 4th BUSY cycle.
    req_cycles = 0; stall_cycles = 0;
    run_op(1, 0, 2'd0, 1, 32'h1003, 32'h0, 1, 1, 5'd7, 32'h0000_0003, 4, 32'h8000_0000);
    chk("lb_be", 64'(seen_be), 64'h8);
    chk("lb_stall_cycles", 64'(stall_cycles), 64'h3);
    chk("lb_data", 64'(mem_data_out), 64'hFFFF_FF80);

    // Half store of 0xBEEF at 0x2002, ack in first BUSY cycle.
    req_cycles = 0;
    run_op(0, 1, 2'd1, 0, 32'h2002, 32'h0000_BEEF, 0, 0, 5'd0, 32'h0000_0023, 1, 32'h0);
    chk("sh_we", 64'(seen_we), 64'h1);
    chk("sh_be", 64'(seen_be), 64'hC);
    chk("sh_wdata", 64'(seen_wdata), 64'hBEEF_0000);
    chk("sh_req_cycles", 64'(req_cycles), 64'h1);
    chk("sh_valid", 64'(valid_out), 64'h1);

    // Misaligned word load.
    req_cycles = 0;
    run_op(1, 0, 2'd2, 0, 32'h0006, 32'h0, 1, 1, 5'd9, 32'h0000_2003, 1, 32'h0);
    chk("mis_err", 64'(misalign_err_out), 64'h1);
    chk("mis_wren", 64'(reg_wr_en_out), 64'h0);
    chk("mis_no_req", 64'(req_cycles), 64'h0);
    idle_cycle();

    // Timeout, then ack on the last allowed cycle.
    req_cycles = 0;
    run_op(1, 0, 2'd2, 0, 32'h0100, 32'h0, 1, 1, 5'd3, 32'h0000_0103, 0, 32'h0);
    chk("to_req_cycles", 64'(req_cycles), 64'h4);
    chk("to_bus_err", 64'(bus_err_out), 64'h1);
    chk("to_wren", 64'(reg_wr_en_out), 64'h0);
    req_cycles = 0;
    run_op(1, 0, 2'd2, 0, 32'h0104, 32'h0, 1, 1, 5'd4, 32'h0000_0203, 4, 32'hCAFE_F00D);
    chk("ack4_req_cycles", 64'(req_cycles), 64'h4);
    chk("ack4_bus_err", 64'(bus_err_out), 64'h0);
    chk("ack4_data", 64'(mem_data_out), 64'hCAFE_F00D);
    idle_cycle();

    // Reset in 2nd BUSY cycle, late ack ignored.
    valid_in = 1; mem_rd_en_in = 1; mem_wr_en_in = 0; mem_size_in = 2'd2; mem_signed_in = 0;
    alu_data_in = 32'h40; reg_wr_en_in = 1; reg_wr_addr_in = 5'd6; instruction_in = 32'h33;
    @(posedge clk); #1;
    exp_rq = pred_req(1'b1, 1'b0, 2'd2, 32'h40, store_data_in);
    exp_req = 1; exp_hold = 0; exp_wb.valid = 0; exp_wb.wben = 0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; valid_in = 1'b0;
    exp_req = 0; exp_wb = '0; exp_wb.mem_chk = 1; exp_hold = 1;
    chk("rst_req", 64'(bus.dmem_req), 64'h0);
    chk("rst_valid", 64'(valid_out), 64'h0);
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    bus.dmem_ack = 1'b0;
    chk("late_ack_valid", 64'(valid_out), 64'h0);
    chk("late_ack_data", 64'(mem_data_out), 64'h0);
    exp_hold = 0;

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      int kind;
      logic [1:0] sz;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      sz = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      run_op(kind == 1 || kind == 3, kind >= 2, sz, 1'($urandom_range(0, 1)), a, $urandom,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom),
             $urandom, $urandom_range(0, 5), $urandom);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH 32, data path width, 32 or 64 only; INSTRUCTION_WIDTH 32, instruction word width; REG_ADDR_WIDTH 5, register index width; ADDR_WIDTH 32, byte address width; ACK_TIMEOUT 16, maximum wait cycles for dmem_ack, at least 1.
REQ-002 The design SHALL use one clock and a synchronous, active-low reset. Ports are listed as name, direction, width, meaning:
REQ-003 clk, in, 1, rising-edge clock.
REQ-004 rst_n, in, 1, synchronous active-low reset.
REQ-005 valid_in, in, 1, EX stage presents an instruction.
REQ-006 mem_rd_en_in / mem_wr_en_in, in, 1 each, load / store; both high SHALL be treated as store.
REQ-007 mem_size_in, in, 2, access size: 0 byte, 1 half, 2 word, 3 doubleword (legal only when DATA_WIDTH=64).
REQ-008 mem_signed_in, in, 1, sign-extend load result.
REQ-009 alu_data_in, in, DATA_WIDTH, ALU result; its low ADDR_WIDTH bits are the byte address for memory ops.
REQ-010 store_data_in, in, DATA_WIDTH, store operand, right-aligned.
REQ-011 write_back_mux_sel_in, reg_wr_en_in, reg_wr_addr_in, instruction_in, in, 1/1/REG_ADDR_WIDTH/INSTRUCTION_WIDTH, WB sideband.
REQ-012 stall_out, out, 1, upstream SHALL hold all inputs stable while high.
REQ-013 dmem_req, dmem_we, out, 1 each, memory request / write strobe.
REQ-014 dmem_addr, out, ADDR_WIDTH, address aligned down to DATA_WIDTH/8 bytes.
REQ-015 dmem_wdata, out, DATA_WIDTH, lane-positioned store data; dmem_be, out, DATA_WIDTH/8, byte enables.
REQ-016 dmem_ack, in, 1, request completed; dmem_rdata, in, DATA_WIDTH, read data valid with ack.
REQ-017 valid_out, write_back_mux_sel_out, alu_data_out, mem_data_out, reg_wr_en_out, reg_wr_addr_out, instruction_out, out, registered WB-side outputs.
REQ-018 misalign_err_out / bus_err_out, out, 1 each, one-cycle error pulses aligned with valid_out.

Function
REQ-019 The FSM SHALL have two states, IDLE and BUSY.
REQ-020 IDLE, valid_in, no memory op: at the next edge, register all sideband to outputs with valid_out=1; latency 1.
REQ-021 IDLE, valid_in, aligned memory op: at the next edge, capture the sideband, drive dmem_req=1, dmem_we, dmem_addr, dmem_be, dmem_wdata, enter BUSY, and drive valid_out=0.
REQ-022 Lane index SHALL be addr[log2(DATA_WIDTH/8)-1:0]. dmem_be SHALL cover 1/2/4/8 bytes starting at the lane. dmem_wdata SHALL be the low store bytes shifted to the lane; other lanes SHALL be 0.
REQ-023 Misaligned access: half with addr[0]≠0, word with addr[1:0]≠0, doubleword with addr[2:0]≠0, or size 3 when DATA_WIDTH=32. No request SHALL be issued; valid_out=1; reg_wr_en_out=0; misalign_err_out=1; latency 1.
REQ-024 BUSY: request outputs SHALL be held constant; stall_out = BUSY AND NOT dmem_ack (combinational).
REQ-025 BUSY with dmem_ack: at the next edge, valid_out=1, dmem_req=0, return to IDLE. For loads, mem_data_out SHALL be the lane extracted from dmem_rdata, sign- or zero-extended to DATA_WIDTH. For stores, mem_data_out=0.
REQ-026 A wait counter SHALL be cleared on entering BUSY and incremented each BUSY cycle without ack. When it reaches ACK_TIMEOUT: dmem_req=0, valid_out=1, reg_wr_en_out=0, bus_err_out=1, return to IDLE.
REQ-027 An ack arriving in the same cycle the counter reaches ACK_TIMEOUT SHALL win, giving a normal completion.
REQ-028 dmem_ack while IDLE SHALL be ignored.
REQ-029 valid_in=0 in IDLE SHALL produce valid_out=0 and reg_wr_en_out=0. The other outputs hold their previous values.
REQ-030 alu_data_out SHALL carry alu_data_in unchanged for every completed instruction.

Reset
REQ-031 When rst_n=0 at a clock edge, all outputs SHALL go to 0 and the FSM and counter to IDLE/0, including mid-BUSY: dmem_req drops at that edge and the pending access is discarded with no valid_out.
REQ-032 stall_out SHALL be 0 during and immediately after reset.

Verification
REQ-033 ALU op, alu_data_in=0x1234, reg_wr_en_in=1, reg 5 -> next cycle valid_out=1, alu_data_out=0x1234, reg_wr_addr_out=5, no dmem_req.
REQ-034 Signed byte load at 0x1003, ack after 3 cycles with rdata=0x80000000 -> dmem_be=4'b1000, stall_out high for 3 cycles, then mem_data_out=0xFFFFFF80.
REQ-035 Half store of 0xBEEF at 0x2002 -> dmem_we=1, dmem_be=4'b1100, dmem_wdata=0xBEEF0000; completes 1 cycle after ack.
REQ-036 Word load at 0x0006 -> no dmem_req, next cycle misalign_err_out=1, reg_wr_en_out=0.
REQ-037 Load, no ack, ACK_TIMEOUT=4 -> dmem_req drops after 4 BUSY cycles, bus_err_out=1; a second case with ack on the 4th cycle completes normally.
REQ-038 rst_n=0 in the 2nd BUSY cycle -> at that edge dmem_req=0, valid_out=0; a late ack is ignored.
